pc_sequencer: RTL and testbench

- Fetch/execute sequencer for the single-cycle-style datapath's program counter.
- Decides each cycle whether the PC advances (pc_next) and which next-address source is selected (PCSrc: add4, jump, jr, branch).
- Holds the PC while instruction or data memory is outstanding, stops on halt, and detects a hung data access.
- Sits between decode/control, the memory controller handshakes (ihit/dhit) and the program counter.

---
 rtl/diaosi_types_pkg.sv | 21 ++
 rtl/pcseq_timeout.sv | 27 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared datapath types: next-PC source select and PC sequencer state.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        ADD4_DIAOSI   = 2'd0,
        JUMP_DIAOSI   = 2'd1,
        JR_DIAOSI     = 2'd2,
        BRANCH_DIAOSI = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } pcseq_state_t;

    // Timeout counter width; covers the full legal DTIMEOUT range.
    localparam int unsigned PCSEQ_TMO_W = 8;

endpackage

// File: rtl/pcseq_timeout.sv
// Clearable, enabled down-counter watchdog; expired is high once the count reaches zero.
module pcseq_timeout #(
    parameter int unsigned LOAD = 63,
    parameter int unsigned W    = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= W'(LOAD);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: strobes PC updates, selects next-address source,
// holds for memory, halts on HALT or on a hung data access.
module pc_sequencer
    import diaosi_types_pkg::*;
#(
    parameter int unsigned DTIMEOUT = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             is_mem,
    input  logic             is_jump,
    input  logic             is_jr,
    input  logic             is_branch,
    input  logic             br_taken,
    input  logic             halt,
    output logic             iREN,
    output logic             dmem_req,
    output logic             pc_next,
    output logic [1:0]       PCSrc,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    pcseq_state_t     state_q, state_d;
    pcsrc_t           pcsrc;
    logic             halted_q, mem_err_q;
    logic [CNT_W-1:0] count_q;
    logic             tmo_clear, tmo_en, tmo_expired, tmo_fire;

    // Load DTIMEOUT-1 on entry so expiry lands on the DTIMEOUT-th dhit-less cycle.
    pcseq_timeout #(
        .LOAD (DTIMEOUT - 1),
        .W    (PCSEQ_TMO_W)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (tmo_clear),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign tmo_clear = (state_q == FETCH) && ihit && !halt && is_mem && !stall;
    assign tmo_en    = (state_q == DATA) && !dhit && !stall;
    assign tmo_fire  = (state_q == DATA) && !dhit && tmo_expired && !stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == HALTED) begin
                halted_q <= 1'b1;
            end
            if (tmo_fire) begin
                mem_err_q <= 1'b1;
            end
            if (pc_next) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (ihit && halt) begin
                    state_d = HALTED;
                end else if (ihit && is_mem) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (dhit) begin
                    state_d = FETCH;
                end else if (tmo_expired) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (stall) begin
            state_d = state_q;
        end
    end

    always_comb begin
        iREN     = 1'b0;
        dmem_req = 1'b0;
        pc_next  = 1'b0;
        pcsrc    = ADD4_DIAOSI;
        unique case (state_q)
            FETCH: begin
                iREN = 1'b1;
                if (ihit && !halt && !is_mem && !stall) begin
                    pc_next = 1'b1;
                    if (is_jr) begin
                        pcsrc = JR_DIAOSI;
                    end else if (is_jump) begin
                        pcsrc = JUMP_DIAOSI;
                    end else if (is_branch && br_taken) begin
                        pcsrc = BRANCH_DIAOSI;
                    end
                end
            end
            DATA: begin
                dmem_req = 1'b1;
                pc_next  = dhit && !stall;
            end
            default: ;
        endcase
    end

    assign PCSrc       = pcsrc;
    assign halted      = halted_q;
    assign mem_err     = mem_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by random
// traffic, compared against an instruction-level behavioural model.
module tb_pc_sequencer;

    localparam int unsigned DTIMEOUT = 4;
    localparam int unsigned CNT_W    = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             stall = 1'b0, ihit = 1'b0, dhit = 1'b0, is_mem = 1'b0;
    logic             is_jump = 1'b0, is_jr = 1'b0, is_branch = 1'b0, br_taken = 1'b0;
    logic             halt = 1'b0;
    logic             iREN, dmem_req, pc_next, halted, mem_err;
    logic [1:0]       PCSrc;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: started = out of reset one cycle; waiting_data = load/store issued
    // and not yet completed; misses = dhit-less cycles spent on it.
    bit               m_started, m_waiting_data, m_stopped, m_err;
    int               m_misses;
    logic [CNT_W-1:0] m_count;

    pc_sequencer #(
        .DTIMEOUT (DTIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .stall       (stall),
        .ihit        (ihit),
        .dhit        (dhit),
        .is_mem      (is_mem),
        .is_jump     (is_jump),
        .is_jr       (is_jr),
        .is_branch   (is_branch),
        .br_taken    (br_taken),
        .halt        (halt),
        .iREN        (iREN),
        .dmem_req    (dmem_req),
        .pc_next     (pc_next),
        .PCSrc       (PCSrc),
        .halted      (halted),
        .mem_err     (mem_err),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started      = 0;
        m_waiting_data = 0;
        m_stopped      = 0;
        m_err          = 0;
        m_misses       = 0;
        m_count        = '0;
    endtask

    task automatic check_outputs();
        logic       e_iren, e_dreq, e_pcn;
        logic [1:0] e_src;
        e_iren = 0; e_dreq = 0; e_pcn = 0; e_src = 2'd0;
        if (m_started && !m_stopped) begin
            if (m_waiting_data) begin
                e_dreq = 1;
                e_pcn  = dhit && !stall;
            end else begin
                e_iren = 1;
                e_pcn  = ihit && !halt && !is_mem && !stall;
                if (e_pcn) begin
                    e_src = is_jr ? 2'd2 : is_jump ? 2'd1 : (is_branch && br_taken) ? 2'd3 : 2'd0;
                end
            end
        end
        chk("iREN", CNT_W'(iREN), CNT_W'(e_iren));
        chk("dmem_req", CNT_W'(dmem_req), CNT_W'(e_dreq));
        chk("pc_next", CNT_W'(pc_next), CNT_W'(e_pcn));
        chk("PCSrc", CNT_W'(PCSrc), CNT_W'(e_src));
        chk("halted", CNT_W'(halted), CNT_W'(m_stopped));
        chk("mem_err", CNT_W'(mem_err), CNT_W'(m_err));
        chk("instr_count", instr_count, m_count);
    endtask

    task automatic model_advance();
        if (stall) return;
        if (!m_started) begin
            m_started = 1;
        end else if (m_stopped) begin
            // sticky until reset
        end else if (m_waiting_data) begin
            if (dhit) begin
                m_waiting_data = 0;
                m_count++;
            end else begin
                m_misses++;
                if (m_misses == int'(DTIMEOUT)) begin
                    m_stopped = 1;
                    m_err     = 1;
                end
            end
        end else if (ihit) begin
            if (halt) begin
                m_stopped = 1;
            end else if (is_mem) begin
                m_waiting_data = 1;
                m_misses       = 0;
            end else begin
                m_count++;
            end
        end
    endtask

    // Called just after a rising edge: drive, check before the next edge, advance.
    task automatic step(input logic s_ihit, input logic s_dhit, input logic s_mem,
                        input logic s_jump, input logic s_jr, input logic s_br,
                        input logic s_taken, input logic s_halt, input logic s_stall);
        ihit = s_ihit; dhit = s_dhit; is_mem = s_mem; is_jump = s_jump; is_jr = s_jr;
        is_branch = s_br; br_taken = s_taken; halt = s_halt; stall = s_stall;
        #3;
        check_outputs();
        @(posedge CLK);
        model_advance();
        #1;
    endtask

    // Async reset pulse; outputs must go quiet before any clock edge.
    task automatic pulse_reset();
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        pulse_reset();

        // Straight-line code: IDLE cycle then one retire per ihit.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("count_after_5", instr_count, 32'd5);

        // JR wins over jump and taken branch; untaken branch is ADD4.
        step(1, 0, 0, 1, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);

        // Load: ihit then three waiting cycles, dhit on the fourth.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // dhit on the last permitted cycle: no error.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("no_err_on_late_dhit", CNT_W'(mem_err), '0);

        // Stall during FETCH with ihit: no retire, iREN held.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Data timeout: never dhit.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("timeout_err", CNT_W'(mem_err), 32'd1);

        pulse_reset();
        // Halt beats jump; later ihits ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("halted_sticky", CNT_W'(halted), 32'd1);
        pulse_reset();
        chk("count_cleared", instr_count, '0);

        // Reset mid-data drops the request immediately.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        pulse_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_stopped && $urandom_range(0, 15) == 0)) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(0, 63) == 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
